// File: rtl/nand_prog_seq.sv
// nand_prog_seq: sequencer for one NAND page-program operation.
// Drives the toggle engine via a req/ack bus-cycle handshake.
module nand_prog_seq #(
  parameter int PAGE_BYTES = 2048,
  parameter int TWB_CYCLES = 16,
  parameter int RB_TIMEOUT = 120000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_start,
  input  logic [11:0] col_addr,
  input  logic [23:0] row_addr,
  input  logic [11:0] byte_count,
  input  logic        buf_valid,
  input  logic [7:0]  buf_data,
  output logic        buf_rd,
  input  logic        NandReady,
  output logic        cyc_req,
  output logic [1:0]  cyc_type,
  output logic [7:0]  cyc_data,
  input  logic        cyc_ack,
  input  logic [7:0]  cyc_rdata,
  output logic        busy,
  output logic        WriteDone,
  output logic        prog_fail,
  output logic        timeout_err,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CMD80   = 4'd1,
    ADDR    = 4'd2,
    DATA    = 4'd3,
    CMD10   = 4'd4,
    TWB     = 4'd5,
    WAIT_RB = 4'd6,
    CMD70   = 4'd7,
    STAT    = 4'd8,
    DONE    = 4'd9
  } state_t;

  localparam logic [1:0] T_CMD = 2'b00;
  localparam logic [1:0] T_ADR = 2'b01;
  localparam logic [1:0] T_DWR = 2'b10;
  localparam logic [1:0] T_DRD = 2'b11;

  localparam logic [12:0] PB = 13'(PAGE_BYTES);
  localparam logic [19:0] TWB_LAST = 20'(TWB_CYCLES - 1);
  localparam logic [19:0] RB_LAST = 20'(RB_TIMEOUT - 1);

  state_t      state, state_n;
  logic        req_n, rd_n, busy_n;
  logic        done_n, fail_n, tmo_n;
  logic [1:0]  type_n;
  logic [7:0]  data_n;
  logic [11:0] col_q, col_n;
  logic [23:0] row_q, row_n;
  logic [11:0] max_q, max_n;
  logic [11:0] bcnt_q, bcnt_n;
  logic [2:0]  acnt_q, acnt_n;
  logic [19:0] tcnt_q, tcnt_n;
  logic        rb_meta, rb_sync;
  logic        acked;
  logic [7:0]  addr_byte;

  assign acked = cyc_req & cyc_ack;
  assign state_dbg = state;

  // two-flop synchronizer for the asynchronous R/B# pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_meta <= 1'b0;
      rb_sync <= 1'b0;
    end else begin
      rb_meta <= NandReady;
      rb_sync <= rb_meta;
    end
  end

  // address byte for the current address cycle
  always_comb begin
    addr_byte = 8'h00;
    unique case (acnt_q)
      3'd0: addr_byte = col_q[7:0];
      3'd1: addr_byte = {4'h0, col_q[11:8]};
      3'd2: addr_byte = row_q[7:0];
      3'd3: addr_byte = row_q[15:8];
      3'd4: addr_byte = row_q[23:16];
      default: addr_byte = 8'h00;
    endcase
  end

  // next-state and next-output logic
  always_comb begin
    state_n = state;
    req_n   = cyc_req;
    type_n  = cyc_type;
    data_n  = cyc_data;
    rd_n    = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    fail_n  = prog_fail;
    tmo_n   = timeout_err;
    col_n   = col_q;
    row_n   = row_q;
    max_n   = max_q;
    bcnt_n  = bcnt_q;
    acnt_n  = acnt_q;
    tcnt_n  = tcnt_q;
    if (acked) req_n = 1'b0;
    case (state)
      IDLE: begin
        if (prog_start) begin
          col_n   = col_addr;
          row_n   = row_addr;
          max_n   = ({1'b0, byte_count} > PB) ? PB[11:0] : byte_count;
          fail_n  = 1'b0;
          tmo_n   = 1'b0;
          busy_n  = 1'b1;
          bcnt_n  = 12'd0;
          acnt_n  = 3'd0;
          tcnt_n  = 20'd0;
          req_n   = 1'b1;
          type_n  = T_CMD;
          data_n  = 8'h80;
          state_n = CMD80;
        end
      end
      CMD80: begin
        if (acked) state_n = ADDR;
      end
      ADDR: begin
        if (acked) begin
          if (acnt_q == 3'd4) begin
            acnt_n  = 3'd0;
            state_n = (max_q == 12'd0) ? CMD10 : DATA;
          end else begin
            acnt_n = acnt_q + 3'd1;
          end
        end else if (!cyc_req) begin
          req_n  = 1'b1;
          type_n = T_ADR;
          data_n = addr_byte;
        end
      end
      DATA: begin
        if (acked) begin
          bcnt_n = bcnt_q + 12'd1;
          if (bcnt_q + 12'd1 == max_q) state_n = CMD10;
        end else if (buf_rd) begin
          req_n  = 1'b1;
          type_n = T_DWR;
        end else if (!cyc_req && buf_valid) begin
          rd_n   = 1'b1;
          data_n = buf_data;
        end
      end
      CMD10: begin
        if (acked) begin
          tcnt_n  = 20'd0;
          state_n = TWB;
        end else if (!cyc_req) begin
          req_n  = 1'b1;
          type_n = T_CMD;
          data_n = 8'h10;
        end
      end
      TWB: begin
        if (tcnt_q == TWB_LAST) begin
          tcnt_n  = 20'd0;
          state_n = WAIT_RB;
        end else begin
          tcnt_n = tcnt_q + 20'd1;
        end
      end
      WAIT_RB: begin
        if (rb_sync) begin
          tcnt_n  = 20'd0;
          state_n = CMD70;
        end else if (tcnt_q == RB_LAST) begin
          tcnt_n  = 20'd0;
          fail_n  = 1'b1;
          tmo_n   = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          tcnt_n = tcnt_q + 20'd1;
        end
      end
      CMD70: begin
        if (acked) begin
          state_n = STAT;
        end else if (!cyc_req) begin
          req_n  = 1'b1;
          type_n = T_CMD;
          data_n = 8'h70;
        end
      end
      STAT: begin
        if (acked) begin
          fail_n  = cyc_rdata[0];
          done_n  = 1'b1;
          state_n = DONE;
        end else if (!cyc_req) begin
          req_n  = 1'b1;
          type_n = T_DRD;
          data_n = 8'h00;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cyc_req     <= 1'b0;
      cyc_type    <= 2'b00;
      cyc_data    <= 8'h00;
      buf_rd      <= 1'b0;
      busy        <= 1'b0;
      WriteDone   <= 1'b0;
      prog_fail   <= 1'b0;
      timeout_err <= 1'b0;
      col_q       <= 12'd0;
      row_q       <= 24'd0;
      max_q       <= 12'd0;
      bcnt_q      <= 12'd0;
      acnt_q      <= 3'd0;
      tcnt_q      <= 20'd0;
    end else begin
      state       <= state_n;
      cyc_req     <= req_n;
      cyc_type    <= type_n;
      cyc_data    <= data_n;
      buf_rd      <= rd_n;
      busy        <= busy_n;
      WriteDone   <= done_n;
      prog_fail   <= fail_n;
      timeout_err <= tmo_n;
      col_q       <= col_n;
      row_q       <= row_n;
      max_q       <= max_n;
      bcnt_q      <= bcnt_n;
      acnt_q      <= acnt_n;
      tcnt_q      <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_nand_prog_seq.sv
// tb_nand_prog_seq: randomized bench for nand_prog_seq.
// Bus-level transaction model, write buffer and R/B# stimulus.
`timescale 1ns/1ps
module tb_nand_prog_seq;

  localparam int PB  = 16;
  localparam int TWB = 16;
  localparam int RBT = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prog_start = 1'b0;
  logic [11:0] col_addr = '0;
  logic [23:0] row_addr = '0;
  logic [11:0] byte_count = '0;
  logic        buf_valid = 1'b0;
  logic [7:0]  buf_data = '0;
  logic        buf_rd;
  logic        NandReady = 1'b1;
  logic        cyc_req;
  logic [1:0]  cyc_type;
  logic [7:0]  cyc_data;
  logic        cyc_ack = 1'b0;
  logic [7:0]  cyc_rdata = '0;
  logic        busy;
  logic        WriteDone;
  logic        prog_fail;
  logic        timeout_err;
  logic [3:0]  state_dbg;

  always #5 clk = ~clk;

  nand_prog_seq #(
    .PAGE_BYTES(PB),
    .TWB_CYCLES(TWB),
    .RB_TIMEOUT(RBT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .prog_start(prog_start),
    .col_addr(col_addr),
    .row_addr(row_addr),
    .byte_count(byte_count),
    .buf_valid(buf_valid),
    .buf_data(buf_data),
    .buf_rd(buf_rd),
    .NandReady(NandReady),
    .cyc_req(cyc_req),
    .cyc_type(cyc_type),
    .cyc_data(cyc_data),
    .cyc_ack(cyc_ack),
    .cyc_rdata(cyc_rdata),
    .busy(busy),
    .WriteDone(WriteDone),
    .prog_fail(prog_fail),
    .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [9:0] expq[$];
  logic [7:0] bufq[$];
  int   wcnt = 0;
  int   dly = 3;
  int   ack_fix = 3;
  int   gap_after = 0;
  int   gap_cnt = 0;
  int   n_dwr = 0;
  int   rb_cnt = 0;
  int   rd_pulses = 0;
  int   done_cnt = 0;
  int   t_cmd10 = 0;
  int   t_ready = 0;
  int   exp_n = 0;
  int   exp_fail = 0;
  int   exp_to = 0;
  bit   rb_hold = 1'b0;
  logic [1:0] cur_t = '0;
  logic [7:0] cur_d = '0;
  logic [7:0] status = '0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // one clock of toggle engine, write buffer and R/B# behaviour
  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    if (buf_rd) begin
      rd_pulses++;
      chk("buf_rd_nonempty", int'(bufq.size() > 0), 1);
      if (bufq.size() > 0) void'(bufq.pop_front());
    end
    if (!reset) begin
      cyc_ack = 1'b0;
      wcnt = 0;
      gap_cnt = 0;
      rb_cnt = 0;
      NandReady = 1'b1;
    end else begin
      if (!busy) chk("idle_quiet", {cyc_req, buf_rd, WriteDone}, 0);
      if (WriteDone) done_cnt++;
      if (gap_cnt > 0) begin
        chk("gap_quiet", {cyc_req, buf_rd}, 0);
        gap_cnt--;
      end
      if (cyc_ack) begin
        cyc_ack = 1'b0;
        chk("req_drop", cyc_req, 0);
      end else if (cyc_req) begin
        if (wcnt == 0) begin
          cur_t = cyc_type;
          cur_d = cyc_data;
          if (expq.size() == 0) begin
            chk("bus_extra", cyc_req, 0);
          end else begin
            e = expq.pop_front();
            chk("bus_type", cyc_type, e[9:8]);
            if (e[9:8] != 2'd3) chk("bus_data", cyc_data, e[7:0]);
            if (cyc_type == 2'd0 && cyc_data == 8'h70) begin
              chk("cmd70_after_twb", int'(cyc - t_cmd10 > TWB), 1);
              chk("cmd70_after_rb", int'(cyc >= t_ready + 3), 1);
            end
          end
        end else begin
          chk("req_stable", {cyc_type, cyc_data}, {cur_t, cur_d});
        end
        wcnt++;
        if (wcnt >= dly) begin
          cyc_ack = 1'b1;
          wcnt = 0;
          cyc_rdata = (cur_t == 2'd3) ? status : 8'($urandom);
          if (cur_t == 2'd0 && cur_d == 8'h10) begin
            t_cmd10 = cyc;
            NandReady = 1'b0;
            rb_cnt = rb_hold ? 0 : $urandom_range(1, 60);
          end
          if (cur_t == 2'd2) begin
            n_dwr++;
            if (n_dwr == gap_after) gap_cnt = 10;
          end
          dly = (ack_fix > 0) ? ack_fix : $urandom_range(1, 4);
        end
      end
      if (rb_cnt > 0) begin
        rb_cnt--;
        if (rb_cnt == 0) begin
          NandReady = 1'b1;
          t_ready = cyc;
        end
      end
    end
    buf_valid = (bufq.size() > 0) && (gap_cnt == 0);
    buf_data = (bufq.size() > 0) ? bufq[0] : 8'h00;
  endtask

  // builds the expected bus transactions and pulses prog_start
  task automatic start_op(input logic [11:0] c, input logic [23:0] r,
                          input logic [11:0] n_in, input logic [7:0] st,
                          input int ga, input bit hold, input int afix,
                          input bit lit);
    int n;
    logic [7:0] b;
    n = (int'(n_in) > PB) ? PB : int'(n_in);
    exp_n = n;
    exp_fail = hold ? 1 : int'(st[0]);
    exp_to = hold ? 1 : 0;
    status = st;
    gap_after = ga;
    rb_hold = hold;
    ack_fix = afix;
    dly = (afix > 0) ? afix : $urandom_range(1, 4);
    n_dwr = 0;
    rd_pulses = 0;
    done_cnt = 0;
    bufq.delete();
    expq.delete();
    expq.push_back({2'd0, 8'h80});
    expq.push_back({2'd1, c[7:0]});
    expq.push_back({2'd1, 4'h0, c[11:8]});
    expq.push_back({2'd1, r[7:0]});
    expq.push_back({2'd1, r[15:8]});
    expq.push_back({2'd1, r[23:16]});
    for (int i = 0; i < n; i++) begin
      b = lit ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      bufq.push_back(b);
      expq.push_back({2'd2, b});
    end
    bufq.push_back(8'($urandom));
    bufq.push_back(8'($urandom));
    expq.push_back({2'd0, 8'h10});
    if (!hold) begin
      expq.push_back({2'd0, 8'h70});
      expq.push_back({2'd3, 8'h00});
    end
    if (lit) begin
      expq = '{10'h080, 10'h123, 10'h101, 10'h1DE, 10'h1BC, 10'h10A,
               10'h211, 10'h222, 10'h233, 10'h244,
               10'h010, 10'h070, 10'h300};
    end
    col_addr = c;
    row_addr = r;
    byte_count = n_in;
    buf_valid = 1'b1;
    buf_data = bufq[0];
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    col_addr = 12'($urandom);
    row_addr = 24'($urandom);
    byte_count = 12'($urandom);
    chk("start_req", cyc_req, 1);
    chk("start_busy", busy, 1);
    chk("start_fail_clr", prog_fail, 0);
    chk("start_to_clr", timeout_err, 0);
  endtask

  // waits for completion and checks the operation summary
  task automatic finish_op();
    int k;
    k = 0;
    while (!WriteDone && k < 3000) begin
      tick();
      k++;
    end
    chk("done_seen", WriteDone, 1);
    chk("done_fail", prog_fail, exp_fail);
    chk("done_timeout", timeout_err, exp_to);
    if (exp_to != 0) begin
      chk("timeout_latency",
          int'(cyc - t_cmd10 >= TWB + RBT && cyc - t_cmd10 <= TWB + RBT + 4), 1);
    end
    tick();
    chk("done_pulse", WriteDone, 0);
    chk("busy_drop", busy, 0);
    chk("fail_hold", prog_fail, exp_fail);
    repeat (6) tick();
    chk("done_count", done_cnt, 1);
    chk("bus_left", expq.size(), 0);
    chk("rd_pulses", rd_pulses, exp_n);
    chk("buf_left", bufq.size(), 2);
    chk("fail_hold2", prog_fail, exp_fail);
    rb_hold = 1'b0;
    NandReady = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    repeat (2) tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_outs", {cyc_req, buf_rd, busy, WriteDone, prog_fail, timeout_err}, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("post_rst_state", state_dbg, 0);

    // reference program with fixed 3-cycle acks and literal bus sequence
    start_op(12'h123, 24'h0ABCDE, 12'd4, 8'h00, 0, 1'b0, 3, 1'b1);
    finish_op();

    // buffer runs dry for 10 cycles after the 2nd data byte
    start_op(12'h456, 24'h111213, 12'd4, 8'h00, 2, 1'b0, 3, 1'b0);
    finish_op();

    // status bit0 set reports a failed program
    start_op(12'h0F0, 24'h00FF00, 12'd3, 8'h01, 0, 1'b0, 0, 1'b0);
    finish_op();
    chk("fail_lit", prog_fail, 1);

    // next start clears prog_fail
    start_op(12'h7FF, 24'hFFFFFF, 12'd2, 8'hFE, 0, 1'b0, 0, 1'b0);
    finish_op();

    // R/B# stuck low ends in timeout, no status read
    start_op(12'h001, 24'h000002, 12'd1, 8'h00, 0, 1'b1, 0, 1'b0);
    finish_op();
    chk("to_lit", timeout_err, 1);

    // zero-length program plus a start pulse while busy
    start_op(12'h222, 24'h333333, 12'd0, 8'h00, 0, 1'b0, 2, 1'b0);
    repeat (3) tick();
    prog_start = 1'b1;
    col_addr = 12'hABC;
    tick();
    prog_start = 1'b0;
    finish_op();

    // byte_count above the page size is clamped
    start_op(12'h010, 24'h020304, 12'd20, 8'h00, 0, 1'b0, 1, 1'b0);
    finish_op();
    chk("clamp_lit", rd_pulses, 16);

    // reset in the middle of the data phase
    start_op(12'h3C5, 24'h123456, 12'd8, 8'h00, 0, 1'b0, 2, 1'b0);
    k = 0;
    while (rd_pulses < 2 && k < 500) begin
      tick();
      k++;
    end
    chk("reach_data", int'(rd_pulses >= 2), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", cyc_req, 0);
    chk("mid_rst_rd", buf_rd, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_state", state_dbg, 0);
    expq.delete();
    bufq.delete();
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    start_op(12'h5A5, 24'hA5A5A5, 12'd3, 8'h00, 0, 1'b0, 0, 1'b0);
    finish_op();

    // randomized programs
    for (int i = 0; i < 12; i++) begin
      start_op(12'($urandom), 24'($urandom), 12'($urandom_range(0, 20)),
               8'($urandom), $urandom_range(0, 4),
               ($urandom_range(0, 5) == 0), 0, 1'b0);
      finish_op();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nand_prog_seq.md
Name: nand_prog_seq

Overview:
- Sequencer for one NAND page-program operation; drives the per-cycle toggle engine (the nCE/CLE/ALE/nRE/nWE generator) through a request/acknowledge cycle interface.
- Issues CMD 0x80, 5 address cycles, N data bytes pulled from the write buffer, CMD 0x10, waits on R/B#, then reads status (CMD 0x70 plus 1 data-read cycle).
- Reports done/fail/timeout to the host-side write logic.

Parameters:
- PAGE_BYTES, 2048, max bytes per program; byte_count is clamped to this.
- TWB_CYCLES, 16, clk cycles waited after CMD 0x10 before R/B# is sampled.
- RB_TIMEOUT, 120000, max clk cycles in WAIT_RB before abort; counter is 20 bits wide.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_start  in  1  one-cycle start pulse; sampled only in IDLE.
- col_addr  in  12  column address; latched at start.
- row_addr  in  24  row (page/block) address; latched at start.
- byte_count  in  12  bytes to program; latched at start; 0 skips the data phase.
- buf_valid  in  1  write buffer has a byte available.
- buf_data  in  8  byte at the head of the write buffer.
- buf_rd  out  1  one-cycle pop of the buffer head.
- NandReady  in  1  R/B# pin (1 = ready); asynchronous, so a 2-flop synchronizer is required.
- cyc_req  out  1  bus-cycle request to the toggle engine.
- cyc_type  out  2  00 CMD, 01 ADDR, 10 DATA_WR, 11 DATA_RD.
- cyc_data  out  8  command, address or data byte.
- cyc_ack  in  1  toggle engine finished the current cycle.
- cyc_rdata  in  8  read byte; valid when cyc_ack=1 on a DATA_RD cycle.
- busy  out  1  operation in progress.
- WriteDone  out  1  one-cycle completion pulse.
- prog_fail  out  1  status bit0 = 1, or timeout.
- timeout_err  out  1  R/B# did not return within RB_TIMEOUT.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (asynchronous, active-low) forces all outputs to 0, state to IDLE and all counters to 0.
- Reset mid-operation drops cyc_req immediately. No recovery of a partial program is attempted.
- All outputs are registered.
- Cycle handshake:
  - cyc_req, cyc_type and cyc_data stay stable from assertion until the clock edge where cyc_ack=1 is sampled.
  - cyc_req goes low the cycle after ack.
  - The next request is asserted no earlier than 1 cycle after that.
  - cyc_ack while cyc_req=0 is ignored.
- States: IDLE, CMD80, ADDR, DATA, CMD10, TWB, WAIT_RB, CMD70, STAT, DONE.
- IDLE:
  - prog_start=1 latches the addresses and min(byte_count, PAGE_BYTES).
  - Clears prog_fail and timeout_err.
  - Sets busy.
  - Cycle N start gives cyc_req=1, CMD 0x80 at N+1.
  - prog_start while busy is ignored.
- ADDR: 5 ADDR cycles in this order: col[7:0], {4'h0,col[11:8]}, row[7:0], row[15:8], row[23:16]. A 3-bit counter wraps to 0 after the 5th ack.
- DATA:
  - When no cycle is outstanding and buf_valid=1: buf_rd=1 for one cycle and buf_data is latched into cyc_data.
  - cyc_req DATA_WR is asserted the next cycle.
  - The 12-bit byte counter increments on each ack.
  - buf_valid=0 stalls with no request and no timeout.
  - Exit to CMD10 after the last ack; with count 0, CMD80→ADDR→CMD10 directly.
  - buf_rd is never asserted beyond the latched count.
- CMD10: CMD 0x10, then TWB counts TWB_CYCLES cycles and ignores R/B#.
- WAIT_RB:
  - Synchronized NandReady=1 goes to CMD70.
  - If the timeout counter reaches RB_TIMEOUT first: timeout_err=1 and prog_fail=1, then DONE, skipping status.
  - Simultaneous ready and timeout in the same cycle counts as ready.
- CMD70: CMD 0x70.
- STAT: one DATA_RD cycle; on ack, prog_fail = cyc_rdata[0].
- DONE: WriteDone=1 for exactly 1 cycle, busy=0 the following cycle, then IDLE.
- prog_fail and timeout_err hold until the next accepted prog_start.

Test Plan:
- Reset low for 3 cycles mid-DATA → cyc_req, buf_rd, busy all 0 at once; state_dbg = IDLE; a new start works normally.
- Start with col=0x123, row=0x0ABCDE, count=4; toggle engine acks after 3 cycles; buffer bytes 11,22,33,44 → bus sequence CMD 80; ADDR 23,01,DE,BC,0A; DWR 11,22,33,44; CMD 10; after R/B# high, CMD 70; status 0x00 → WriteDone pulse, prog_fail=0.
- buf_valid dropped for 10 cycles after byte 2 → no request or buf_rd during the gap; exactly 4 buf_rd pulses total.
- Status returns 0x01 → prog_fail=1 with WriteDone; next start clears prog_fail.
- NandReady held low, RB_TIMEOUT=100 → timeout_err=1, prog_fail=1, WriteDone pulse; no CMD 70 issued.
- count=0, plus prog_start pulsed again while busy → no DATA_WR cycles; the second start is ignored; one WriteDone only.
